// File: rtl/dotmatrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : dotmatrix_scan
//  Description : Column-multiplexed scan driver for a 5x7 LED dot matrix.
//                Holds a double-buffered frame (7 columns x 5 rows). The
//                back buffer is written by the host. On commit it is copied
//                to the front buffer at the next frame boundary. Columns are
//                driven one at a time for DWELL_CYCLES clocks, and a
//                BLANK_CYCLES gap with all outputs low separates columns.
//
//  Ports       : clk          - system clock, rising edge
//                rst          - synchronous active-high reset
//                en           - scan enable; low forces blanking / idle
//                wr_en        - back-buffer write strobe
//                wr_col[2:0]  - column address 0..6 (7 is ignored)
//                wr_data[4:0] - row pattern, bit0 = top row
//                commit       - request swap at next frame boundary
//                swap_pending - commit waiting for the frame boundary
//                frame_start  - 1-clock pulse at start of column-0 drive
//                row[4:0]     - row drive, active-high
//                column[6:0]  - one-hot column select, active-high
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dotmatrix_scan #(
    parameter int DWELL_CYCLES = 5000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_col,
    input  logic [4:0] wr_data,
    input  logic       commit,
    output logic       swap_pending,
    output logic       frame_start,
    output logic [4:0] row,
    output logic [6:0] column
);

    // Counter only needs to reach the larger of the two phase lengths minus one.
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       c_last_col   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       col_idx_q, col_idx_d;
    logic [4:0]       front_q [7];
    logic [4:0]       front_d [7];
    logic [4:0]       back_q  [7];
    logic [4:0]       back_d  [7];
    logic             swap_pending_q, swap_pending_d;
    logic             frame_start_q, frame_start_d;
    logic [4:0]       row_q, row_d;
    logic [6:0]       column_q, column_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        col_idx_d      = col_idx_q;
        front_d        = front_q;
        back_d         = back_q;
        swap_pending_d = swap_pending_q | commit;
        frame_start_d  = 1'b0;
        row_d          = 5'd0;
        column_d       = 7'd0;

        // Host writes always land in the back buffer, independent of scan state.
        if (wr_en && (wr_col != 3'd7)) begin
            back_d[wr_col] = wr_data;
        end

        if (!en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            col_idx_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == c_blank_last) begin
                        // Outputs are registered, so load the drive values on
                        // the edge that enters DRIVE.
                        state_d       = ST_DRIVE;
                        cnt_d         = '0;
                        column_d      = 7'd1 << col_idx_q;
                        row_d         = front_q[col_idx_q];
                        frame_start_d = (col_idx_q == 3'd0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == c_dwell_last) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (col_idx_q == c_last_col) begin
                            col_idx_d = 3'd0;
                            // Frame boundary: copy the back buffer as it stood
                            // before this edge. A commit on this very edge
                            // starts a new pending request for the next frame.
                            if (swap_pending_q) begin
                                front_d        = back_q;
                                swap_pending_d = commit;
                            end
                        end else begin
                            col_idx_d = col_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        column_d = 7'd1 << col_idx_q;
                        row_d    = front_q[col_idx_q];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            col_idx_q      <= 3'd0;
            front_q        <= '{default: 5'd0};
            back_q         <= '{default: 5'd0};
            swap_pending_q <= 1'b0;
            frame_start_q  <= 1'b0;
            row_q          <= 5'd0;
            column_q       <= 7'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            col_idx_q      <= col_idx_d;
            front_q        <= front_d;
            back_q         <= back_d;
            swap_pending_q <= swap_pending_d;
            frame_start_q  <= frame_start_d;
            row_q          <= row_d;
            column_q       <= column_d;
        end
    end

    assign swap_pending = swap_pending_q;
    assign frame_start  = frame_start_q;
    assign row          = row_q;
    assign column       = column_q;

endmodule
`default_nettype wire

// File: tb/tb_dotmatrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dotmatrix_scan
//  Description : Self-checking bench for dotmatrix_scan. A time-based model
//                (position within the frame derived from cycles since enable)
//                pushes the expected outputs after every clock edge into a
//                queue; a monitor pops and compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dotmatrix_scan;

    localparam int D    = 4;
    localparam int B    = 2;
    localparam int SLOT = B + D;
    localparam int P    = 7 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [4:0] wr_data;
    logic       commit;
    logic       swap_pending;
    logic       frame_start;
    logic [4:0] row;
    logic [6:0] column;

    always #5 clk = ~clk;

    dotmatrix_scan #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .commit       (commit),
        .swap_pending (swap_pending),
        .frame_start  (frame_start),
        .row          (row),
        .column       (column)
    );

    typedef struct packed {
        logic [4:0] row;
        logic [6:0] column;
        logic       pend;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: frame position is simply the number of edges since the
    // enabling edge, taken modulo the frame period.
    bit         m_run  = 1'b0;
    int         m_k    = 0;
    logic [4:0] m_front [7];
    logic [4:0] m_back  [7];
    bit         m_pend = 1'b0;

    always @(posedge clk) begin : model
        logic [4:0] old_back [7];
        bit         old_pend;
        exp_t       e;
        int         s;
        int         c;
        cyc++;
        old_back = m_back;
        old_pend = m_pend;
        if (rst) begin
            m_run = 1'b0;
            m_k   = 0;
            m_pend = 1'b0;
            for (int i = 0; i < 7; i++) begin
                m_front[i] = 5'd0;
                m_back[i]  = 5'd0;
            end
        end else begin
            if (wr_en && (int'(wr_col) <= 6)) m_back[wr_col] = wr_data;
            m_pend = old_pend | commit;
            if (!en) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_k   = 0;
            end else begin
                m_k++;
                if ((m_k % P) == 0 && old_pend) begin
                    m_front = old_back;
                    m_pend  = commit;
                end
            end
        end
        e = '0;
        e.pend = m_pend;
        if (m_run) begin
            s = m_k % P;
            c = s / SLOT;
            if ((s % SLOT) >= B) begin
                e.column = 7'(1 << c);
                e.row    = m_front[c];
            end
            e.fs = (s == B);
        end
        q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
            e = q.pop_front();
            if ({row, column, swap_pending, frame_start} !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got row=%h col=%b pend=%b fs=%b exp row=%h col=%b pend=%b fs=%b",
                         cyc, row, column, swap_pending, frame_start,
                         e.row, e.column, e.pend, e.fs);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    // Advance until the model's frame position (after the latest edge) equals target.
    task automatic wait_pos(input int target);
        int n = 0;
        while (!(m_run && ((m_k % P) == target))) begin
            tick();
            n++;
            if (n > 3 * P) begin
                checks++;
                errors++;
                $display("FAIL wait_pos target=%0d not reached got k=%0d", target, m_k);
                return;
            end
        end
    endtask

    task automatic write_col(input int col, input logic [4:0] data);
        wr_en   = 1'b1;
        wr_col  = 3'(col);
        wr_data = data;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_col  = 3'd0;
        wr_data = 5'd0;
        commit  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();

        // Basic scan: pattern k+1, committed before enabling.
        for (int k = 0; k < 7; k++) write_col(k, 5'(k + 1));
        commit = 1'b1;
        tick();
        en = 1'b1;
        repeat (2 * P + 5) tick();

        // Deferred swap: new pattern written mid-frame.
        wait_pos(3 * SLOT);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) commit = 1'b1;
            write_col(k, 5'(~(k + 1)));
        end
        repeat (2 * P) tick();

        // Commit one clock before the boundary edge.
        for (int k = 0; k < 7; k++) write_col(k, 5'($urandom_range(0, 31)));
        wait_pos(P - 2);
        commit = 1'b1;
        tick();
        repeat (P) tick();

        // Write to column 3 plus commit on the boundary edge itself.
        wait_pos(P - 1);
        wr_en   = 1'b1;
        wr_col  = 3'd3;
        wr_data = 5'h15;
        commit  = 1'b1;
        tick();
        repeat (2 * P) tick();

        // Ignored address and repeated commit.
        write_col(7, 5'h1F);
        commit = 1'b1;
        tick();
        commit = 1'b1;
        tick();
        repeat (2 * P) tick();

        // Drop enable during column 4 drive.
        wait_pos(4 * SLOT + B + 1);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (P + 10) tick();

        // Reset during drive with a swap pending.
        write_col(1, 5'h0A);
        commit = 1'b1;
        tick();
        wait_pos(2 * SLOT + B + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (P + 10) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 599) == 0);
            if (en) en = ($urandom_range(0, 249) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_col  = 3'($urandom_range(0, 7));
            wr_data = 5'($urandom_range(0, 31));
            commit  = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        rst    = 1'b0;
        wr_en  = 1'b0;
        commit = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dotmatrix_scan.md
Name: dotmatrix_scan

Overview:
Column-multiplexed scan driver for the 5x7 LED dot matrix. Holds a double-buffered 7-column x 5-row frame and cycles through the columns one at a time. Each column is driven for a fixed dwell, with a blanking gap between columns. Outputs feed the matrix pins directly: row[4:0] goes through the ULN2803 Darlington stage, column[6:0] is direct. A LED lights when its row bit and its column bit are both high.

Parameters:
DWELL_CYCLES, 5000, clocks each column is driven (>=1)
BLANK_CYCLES, 50, clocks all outputs are held low between columns (>=1)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  scan enable; low forces blanking
wr_en  input  1  write strobe for the back buffer
wr_col  input  3  column address for a write, 0..6
wr_data  input  5  row pattern for that column; bit0 = row[0] (top)
commit  input  1  one-cycle request to present the back buffer at the next frame boundary
swap_pending  output  1  a commit is waiting for the frame boundary
frame_start  output  1  one-cycle pulse when column 0 begins its DRIVE phase
row  output  5  row drive, active-high
column  output  7  column select, one-hot active-high; bit k = column k

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset clears: row, column, swap_pending, frame_start, front buffer, back buffer, col_idx, phase counter. State goes to IDLE.
- All outputs are registered.
- States:
  - IDLE: outputs 0.
  - BLANK: outputs 0, runs for BLANK_CYCLES clocks.
  - DRIVE: column = one-hot(col_idx) and row = front[col_idx], runs for DWELL_CYCLES clocks.
- Transitions:
  - IDLE -> BLANK on the first clock with en=1.
  - BLANK -> DRIVE when the phase counter reaches BLANK_CYCLES-1. Counter resets to 0.
  - DRIVE -> BLANK when the counter reaches DWELL_CYCLES-1. col_idx increments, 6 wraps to 0.
- Timing from enable: with en sampled high in IDLE at edge N, column first goes non-zero after edge N+BLANK_CYCLES. It stays non-zero for exactly DWELL_CYCLES clocks.
- Frame period is 7*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- Frame boundary is the DRIVE->BLANK transition of column 6:
  - If swap_pending=1 at that edge: front <= back (all 7 columns, atomic), and swap_pending <= 0 on the same edge.
  - A write and a commit arriving on the boundary edge itself are not part of this swap.
- frame_start is high for the first clock of column-0 DRIVE, whether or not a swap occurred.
- Writes:
  - wr_en=1 with wr_col<=6: back[wr_col] <= wr_data on that edge.
  - wr_col 7 is ignored with no side effect.
  - The front buffer is never written directly.
- Commit:
  - commit=1 sets swap_pending on the next edge.
  - A commit while already pending has no additional effect.
  - Write and commit on the same edge: the write is included in the pending swap.
  - Writes while pending are also included, provided they land before the boundary edge.
- en deassert in any state: next edge forces row=0, column=0, state IDLE, col_idx=0, counter=0.
  - Buffers and swap_pending are retained.
  - No swap occurs while in IDLE.
- rst mid-scan: next edge gives reset values. A pending commit is discarded.
- Column never has more than one bit set. Row and column are never non-zero while in BLANK.

Test Plan:
- Reset/idle (DWELL=4, BLANK=2): assert rst 3 clocks, en=0 -> row=0, column=0, swap_pending=0 for 20 clocks.
- Basic scan: write back[k]=k+1 for k=0..6, commit, en=1.
  - Expect column 7'b0000001 for 4 clocks after 2 blank clocks; row=0 during the first frame (front still clear).
  - Swap happens at the end of column 6.
  - Second frame shows row=5'd1 with column bit0, then row=5'd2 with bit1, and so on.
  - frame_start pulses every 42 clocks.
- Deferred swap: mid-frame while showing pattern A, write B to all columns and commit -> swap_pending=1, and the display keeps A for the remainder of the frame. B appears from column 0 of the next frame; swap_pending clears on the boundary edge.
- Boundary collisions:
  - Commit one clock before the column-6 DRIVE->BLANK edge -> swap occurs at that boundary.
  - Write to column 3 plus commit exactly on that edge -> swap deferred one frame, swap_pending remains 1.
- Invalid/edge writes: wr_col=7 with data 5'h1F -> no buffer change. Repeated commit while pending -> single swap.
- Enable/reset mid-operation:
  - Drop en during column 4 DRIVE -> outputs 0 next clock. Re-raise en -> scan restarts at column 0 after 2 blank clocks, with the buffer content intact.
  - Assert rst during DRIVE with swap pending -> all cleared, no swap.
